// File: rtl/vec_proc_pkg.sv
// Shared opcodes, FSM state encoding and instruction field layout for vec_proc_core.
package vec_proc_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  // Instruction layout, MSB to LSB: op, dst, src1, src2, addr.
  function automatic int instr_w(int reg_w, int addr_w);
    return 2 + 3 * reg_w + addr_w;
  endfunction

  function automatic int op_lsb(int reg_w, int addr_w);
    return 3 * reg_w + addr_w;
  endfunction

  function automatic int dst_lsb(int reg_w, int addr_w);
    return 2 * reg_w + addr_w;
  endfunction

  function automatic int src1_lsb(int reg_w, int addr_w);
    return reg_w + addr_w;
  endfunction

  function automatic int src2_lsb(int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/vec_proc_mul.sv
// Iterative unsigned multiplier: consumes MUL_CHUNK bits of b per cycle, DATA_W/MUL_CHUNK cycles.
// prod is the accumulator including the current partial product, so it is final while last is high.
module vec_proc_mul #(
  parameter int DATA_W    = 512,
  parameter int MUL_CHUNK = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  last,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int MUL_CYC = DATA_W / MUL_CHUNK;
  localparam int K_W     = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  logic [DATA_W-1:0]           a_q;
  logic [DATA_W-1:0]           b_q;
  logic [K_W-1:0]              k_q;
  logic                        busy_q;
  logic [2*DATA_W-1:0]         acc_q;
  logic [DATA_W+MUL_CHUNK-1:0] part;
  logic [2*DATA_W-1:0]         pp;

  // b is shifted down each cycle so the active chunk always sits in the low bits.
  assign part = {{MUL_CHUNK{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q[MUL_CHUNK-1:0]};
  assign pp   = {{(DATA_W-MUL_CHUNK){1'b0}}, part} << (int'(k_q) * MUL_CHUNK);
  assign prod = acc_q + pp;
  assign busy = busy_q;
  assign last = busy_q && (k_q == K_W'(MUL_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      k_q    <= '0;
      acc_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= prod;
      b_q   <= b_q >> MUL_CHUNK;
      k_q   <= k_q + K_W'(1);
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_proc_core.sv
// Register-file vector core with add/mul/load/store, valid/ready issue and a host preload port.
// Define VEC_PROC_MUL_EN to build the multiplier; otherwise opcode 01 is illegal and sets err.
module vec_proc_core
  import vec_proc_pkg::*;
#(
  parameter int  DATA_W    = 512,
  parameter int  NREG      = 4,
  parameter int  ADDR_W    = 9,
  parameter int  MUL_CHUNK = 64,
  localparam int REG_W     = $clog2(NREG)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [instr_w(REG_W, ADDR_W)-1:0]    instr,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic                                 host_we,
  input  logic [ADDR_W-1:0]                    host_addr,
  input  logic [DATA_W-1:0]                    host_data,
  output logic [NREG*DATA_W-1:0]               regs,
  output logic [DATA_W-1:0]                    hi,
  output logic                                 done,
  output logic                                 err
);

  if ((DATA_W % MUL_CHUNK) != 0) begin : g_bad_chunk
    $error("MUL_CHUNK must divide DATA_W");
  end

  state_t              state_q, state_nxt;
  logic [DATA_W-1:0]   reg_q [NREG];
  logic [DATA_W-1:0]   hi_q;
  logic                done_q, err_q;
  logic [REG_W-1:0]    dst_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   mem_q;

  logic [1:0]          op;
  logic [REG_W-1:0]    dst_f, src1_f, src2_f;
  logic [ADDR_W-1:0]   addr_f;
  logic                accept, store_acc, load_acc;
  logic [DATA_W:0]     sum;

  assign op     = instr[op_lsb(REG_W, ADDR_W) +: 2];
  assign dst_f  = instr[dst_lsb(REG_W, ADDR_W) +: REG_W];
  assign src1_f = instr[src1_lsb(REG_W, ADDR_W) +: REG_W];
  assign src2_f = instr[src2_lsb(ADDR_W) +: REG_W];
  assign addr_f = instr[ADDR_W-1:0];

  assign accept    = instr_valid && instr_ready;
  assign store_acc = accept && (op == OP_STORE) && !rst;
  assign load_acc  = accept && (op == OP_LOAD);
  assign sum       = {1'b0, reg_q[src1_f]} + {1'b0, reg_q[src2_f]};

`ifdef VEC_PROC_MUL_EN
  logic                mul_busy, mul_last;
  logic [2*DATA_W-1:0] mul_prod;

  vec_proc_mul #(.DATA_W(DATA_W), .MUL_CHUNK(MUL_CHUNK)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && (op == OP_MUL)),
    .a     (reg_q[src1_f]),
    .b     (reg_q[src2_f]),
    .busy  (mul_busy),
    .last  (mul_last),
    .prod  (mul_prod)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && op == OP_LOAD) state_nxt = ST_LOAD;
`ifdef VEC_PROC_MUL_EN
        else if (accept && op == OP_MUL) state_nxt = ST_MUL;
`endif
      end
      ST_LOAD: state_nxt = ST_IDLE;
`ifdef VEC_PROC_MUL_EN
      ST_MUL:  if (mul_last || !mul_busy) state_nxt = ST_IDLE;
`else
      ST_MUL:  state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q  <= '{default: '0};
      hi_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      dst_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        dst_q <= dst_f;
        case (op)
          OP_ADD: begin
            reg_q[dst_f] <= sum[DATA_W-1:0];
            hi_q         <= {{(DATA_W-1){1'b0}}, sum[DATA_W]};
            done_q       <= 1'b1;
          end
          OP_STORE: done_q <= 1'b1;
`ifndef VEC_PROC_MUL_EN
          OP_MUL: begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
      if (state_q == ST_LOAD) begin
        reg_q[dst_q] <= mem_q;
        done_q       <= 1'b1;
      end
`ifdef VEC_PROC_MUL_EN
      if (state_q == ST_MUL && mul_last) begin
        reg_q[dst_q] <= mul_prod[DATA_W-1:0];
        hi_q         <= mul_prod[2*DATA_W-1:DATA_W];
        done_q       <= 1'b1;
      end
`endif
    end
  end

  // Single write port: an accepted store takes priority and the host write is dropped.
  always_ff @(posedge clk) begin
    if (store_acc)    mem[addr_f]    <= reg_q[dst_f];
    else if (host_we) mem[host_addr] <= host_data;
    if (load_acc)     mem_q          <= mem[addr_f];
  end

  for (genvar i = 0; i < NREG; i++) begin : g_regs
    assign regs[i*DATA_W +: DATA_W] = reg_q[i];
  end

  assign hi   = hi_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_vec_proc_core.sv
// Scoreboard bench for vec_proc_core: a behavioural model predicts each retire, a monitor checks it on done.
`timescale 1ns/1ps
module tb_vec_proc_core;
  import vec_proc_pkg::*;

  localparam int DW   = 512;
  localparam int NREG = 4;
  localparam int AW   = 9;
  localparam int RW   = 2;
  localparam int IW   = 2 + 3 * RW + AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [IW-1:0]   instr;
  logic            instr_valid, instr_ready;
  logic            host_we;
  logic [AW-1:0]   host_addr;
  logic [DW-1:0]   host_data;
  logic [NREG*DW-1:0] regs;
  logic [DW-1:0]   hi;
  logic            done, err;

  vec_proc_core #(.DATA_W(DW), .NREG(NREG), .ADDR_W(AW), .MUL_CHUNK(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .regs        (regs),
    .hi          (hi),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string         name;
    int            dst;
    bit            chk_reg;
    logic [DW-1:0] exp_reg;
    logic [DW-1:0] exp_hi;
    int            lat;
    int            acc_cyc;
  } rec_t;

  rec_t sb[$];
  rec_t mon_r;

  logic [DW-1:0] m_regs [NREG];
  logic [DW-1:0] m_hi;
  logic [DW-1:0] m_mem [2**AW];
  bit            m_err;

  task automatic reset_model();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_hi  = '0;
    m_err = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_reg%0d", tag, i), regs[i*DW +: DW], '0);
    check({tag, "_hi"},    hi, '0);
    check({tag, "_ready"}, DW'(instr_ready), DW'(1));
    check({tag, "_done"},  DW'(done), '0);
    check({tag, "_err"},   DW'(err), '0);
  endtask

  task automatic host_wr(input int addr, input logic [DW-1:0] data);
    host_we   = 1'b1;
    host_addr = AW'(addr);
    host_data = data;
    @(negedge clk);
    host_we   = 1'b0;
    m_mem[addr] = data;
  endtask

  // Drives one instruction from a negedge, waits for ready, predicts the retire, returns after the accept edge.
  task automatic issue(input logic [1:0] op, input int dst, input int s1, input int s2,
                       input int addr, input bit push, output int waits);
    rec_t r;
    logic [DW:0]     s;
    logic [2*DW-1:0] p;
    instr       = {op, RW'(dst), RW'(s1), RW'(s2), AW'(addr)};
    instr_valid = 1'b1;
    waits       = 0;
    while (!instr_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) begin
      check("ready_timeout", DW'(instr_ready), DW'(1));
      instr_valid = 1'b0;
      return;
    end
    r.dst = dst; r.chk_reg = 1'b1; r.lat = 1; r.acc_cyc = cyc;
    case (op)
      OP_ADD: begin
        r.name = "add";
        s = {1'b0, m_regs[s1]} + {1'b0, m_regs[s2]};
        m_regs[dst] = s[DW-1:0];
        m_hi = {{(DW-1){1'b0}}, s[DW]};
      end
      OP_MUL: begin
        r.name = "mul";
`ifdef VEC_PROC_MUL_EN
        p = {{DW{1'b0}}, m_regs[s1]} * {{DW{1'b0}}, m_regs[s2]};
        m_regs[dst] = p[DW-1:0];
        m_hi = p[2*DW-1:DW];
        r.lat = DW / 64 + 1;
`else
        p = '0;
        m_err = 1'b1;
`endif
      end
      OP_LOAD: begin
        r.name = "load";
        m_regs[dst] = m_mem[addr];
        r.lat = 2;
      end
      default: begin
        r.name = "store";
        m_mem[addr] = m_regs[dst];
        r.chk_reg = 1'b0;
      end
    endcase
    r.exp_reg = m_regs[dst];
    r.exp_hi  = m_hi;
    if (push) sb.push_back(r);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", DW'(done), '0);
      end else begin
        mon_r = sb.pop_front();
        check({mon_r.name, "_lat"}, DW'(cyc - mon_r.acc_cyc), DW'(mon_r.lat));
        check({mon_r.name, "_hi"}, hi, mon_r.exp_hi);
        if (mon_r.chk_reg)
          check({mon_r.name, "_reg"}, regs[mon_r.dst*DW +: DW], mon_r.exp_reg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    host_we = 1'b0; host_addr = '0; host_data = '0;
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("por");

    // load + add: r2 = 3 + 7
    host_wr(5, DW'(3));
    host_wr(6, DW'(7));
    issue(OP_LOAD, 0, 0, 0, 5, 1, w);
    issue(OP_LOAD, 1, 0, 0, 6, 1, w);
    issue(OP_ADD,  2, 0, 1, 0, 1, w);

    // carry out of all-ones + 1
    host_wr(1, '1);
    host_wr(2, DW'(1));
    issue(OP_LOAD, 0, 0, 0, 1, 1, w);
    issue(OP_LOAD, 1, 0, 0, 2, 1, w);
    issue(OP_ADD,  2, 0, 1, 0, 1, w);

`ifdef VEC_PROC_MUL_EN
    host_wr(3, DW'(1) << (DW - 1));
    host_wr(4, DW'(4));
    issue(OP_LOAD, 0, 0, 0, 3, 1, w);
    issue(OP_LOAD, 1, 0, 0, 4, 1, w);
    issue(OP_MUL,  3, 0, 1, 0, 1, w);
    issue(OP_STORE, 3, 0, 0, 9, 1, w);
    check("mul_busy_cycles", DW'(w), DW'(8));
    issue(OP_LOAD, 0, 0, 0, 9, 1, w);
`else
    issue(OP_MUL, 0, 0, 1, 0, 1, w);
    @(negedge clk);
    check("illegal_err", DW'(err), DW'(1));
`endif

    // host write to the same cycle as an accepted store: store must win
    host_we   = 1'b1;
    host_addr = AW'(9);
    host_data = {8{64'h5555_5555_5555_5555}};
    issue(OP_STORE, 1, 0, 0, 9, 1, w);
    host_we = 1'b0;
    issue(OP_LOAD, 2, 0, 0, 9, 1, w);

    repeat (3) @(negedge clk);
    check("err_sticky", DW'(err), DW'(m_err));

`ifdef VEC_PROC_MUL_EN
    issue(OP_MUL, 3, 1, 1, 0, 0, w);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_reset("mid_mul");
    repeat (12) @(negedge clk);
`endif

    issue(OP_LOAD, 3, 0, 0, 9, 0, w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_reset("mid_load");
    repeat (4) @(negedge clk);
    check("mid_load_r3_after", regs[3*DW +: DW], '0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
